// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type,
// sizing constants and the byte-enable mask helper.
package lsu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned LSU_DEPTH_WORDS = 256;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_t;

    // Bit mask covering the bytes touched by an access of the given size at the given offset.
    function automatic logic [XLEN-1:0] be_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [XLEN-1:0] m;
        m = '0;
        case (funct3[1:0])
            2'b00:   m = 32'h0000_00FF << {off, 3'b000};
            2'b01:   m = 32'h0000_FFFF << {off[1], 4'b0000};
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load lane extraction: selects the byte/half addressed by byte_off from the
// memory word and sign- or zero-extends it according to funct3.
// Ports: funct3 (access type), byte_off (addr[1:0]), word (raw memory word),
//        data_c (extended 32-bit result, combinational).
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'(word >> {byte_off, 3'b000});
        half_lane = 16'(word >> {byte_off[1], 4'b0000});
        case (funct3)
            F3_B:    data_c = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data_c = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data_c = {24'h0, byte_lane};
            F3_HU:   data_c = {16'h0, half_lane};
            default: data_c = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Full-word stores write in the accept cycle; byte/half stores do a
// read-modify-write through the MERGE state. Responses arrive one cycle
// after completion with error flags and the extended load result.
// Ports: clk, rst_n; req_* request channel with req_ready; resp_valid,
//        resp_rdata, misalign_err, access_fault response; mem_* memory port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = LSU_DEPTH_WORDS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            misalign_err,
    output logic            access_fault,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_t      state_q, state_d;
    logic            resp_valid_d, misalign_d, fault_d;
    logic [XLEN-1:0] resp_rdata_d;
    logic [XLEN-1:0] merge_addr_q, merge_addr_d;
    logic [XLEN-1:0] merge_old_q, merge_old_d;
    logic [XLEN-1:0] merge_mask_q, merge_mask_d;
    logic [XLEN-1:0] merge_wdata_q, merge_wdata_d;
    logic [XLEN-1:0] load_data;
    logic            illegal_f3, misaligned, out_of_range;

    lsu_load_extract u_extract (
        .funct3   (req_funct3),
        .byte_off (req_addr[1:0]),
        .word     (mem_read_data),
        .data_c   (load_data)
    );

    // Request classification; stores only accept B/H/W.
    always_comb begin
        illegal_f3   = (req_funct3[1:0] == 2'b11) ||
                       (req_funct3[2] && (req_we || req_funct3[1]));
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, req_addr[31:2]} >= XLEN'(DEPTH_WORDS);
    end

    // Next-state, memory drive and response staging.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {req_addr[31:2], 2'b00};
        mem_write_data = req_wdata;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = '0;
        misalign_d     = 1'b0;
        fault_d        = 1'b0;
        merge_addr_d   = merge_addr_q;
        merge_old_d    = merge_old_q;
        merge_mask_d   = merge_mask_q;
        merge_wdata_d  = merge_wdata_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal_f3) begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (misaligned) begin
                        resp_valid_d = 1'b1;
                        misalign_d   = 1'b1;
                    end else if (out_of_range) begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (!req_we) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                    end else if (req_funct3 == F3_W) begin
                        mem_write    = rst_n;
                        resp_valid_d = 1'b1;
                    end else begin
                        // Sub-word store: capture the old word and write it back merged next cycle.
                        merge_addr_d  = {req_addr[31:2], 2'b00};
                        merge_old_d   = mem_read_data;
                        merge_mask_d  = be_mask(req_funct3, req_addr[1:0]);
                        merge_wdata_d = (req_wdata << {req_addr[1:0], 3'b000}) &
                                        be_mask(req_funct3, req_addr[1:0]);
                        state_d       = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_write      = rst_n;
                mem_address    = merge_addr_q;
                mem_write_data = (merge_old_q & ~merge_mask_q) | (merge_wdata_q & merge_mask_q);
                resp_valid_d   = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, merge and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            misalign_err  <= 1'b0;
            access_fault  <= 1'b0;
            merge_addr_q  <= '0;
            merge_old_q   <= '0;
            merge_mask_q  <= '0;
            merge_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            resp_valid    <= resp_valid_d;
            resp_rdata    <= resp_rdata_d;
            misalign_err  <= misalign_d;
            access_fault  <= fault_d;
            merge_addr_q  <= merge_addr_d;
            merge_old_q   <= merge_old_d;
            merge_mask_q  <= merge_mask_d;
            merge_wdata_q <= merge_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// each response at issue time; a monitor pops and compares on resp_valid.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, misalign_err, access_fault, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .misalign_err   (misalign_err),
        .access_fault   (access_fault),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: 256 words, combinational read, preload port for the bench.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    always_ff @(posedge clk) begin
        if (pre_we)         mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[9:2]];

    // Reference model: flat byte array.
    logic [7:0] rmem [1024];

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        af;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int wcount = 0;
    int rlow   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          size;
        bit          legal;
        logic [31:0] v;
        e.rdata = '0; e.mis = 1'b0; e.af = 1'b0;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!legal) e.af = 1'b1;
        else if ((addr & 32'(size - 1)) != 32'd0) e.mis = 1'b1;
        else if (addr >= 32'd1024) e.af = 1'b1;
        else if (we) begin
            for (int i = 0; i < size; i++) rmem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rmem[addr[9:0] + 10'(i)];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
        end
        return e;
    endfunction

    // Monitor: scoreboard compare on every response, reset-time checks, event counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_mem_write", 32'(mem_write), 32'd0);
            check("reset_resp_valid", 32'(resp_valid), 32'd0);
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid expected=none t=%0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("misalign_err", 32'(misalign_err), 32'(e.mis));
                check("access_fault", 32'(access_fault), 32'(e.af));
            end
        end
        if (mem_write) wcount++;
        if (rst_n && !req_ready) rlow++;
    end

    // Drive one request (called at posedge+1); waits for acceptance with a bound.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit expect_resp);
        bit done;
        done       = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (expect_resp) exp_q.push_back(model(we, f3, addr, wdata));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [2:0] f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          size;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;

        // Preload memory while held in reset.
        #1;
        for (int i = 0; i < 256; i++) begin
            pre_we   = 1'b1;
            pre_idx  = 8'(i);
            pre_data = $urandom;
            for (int b = 0; b < 4; b++) rmem[4*i + b] = pre_data[8*b +: 8];
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_fault", 32'(access_fault), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("post_rst_mem_write", 32'(mem_write), 32'd0);
        check("post_rst_rdata", resp_rdata, 32'd0);
        @(posedge clk);
        #1;

        // SW then LW.
        wcount = 0;
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        idle(3);
        check("sw_write_cycles", 32'(wcount), 32'd1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        idle(2);

        // SB read-modify-write.
        issue(1'b1, 3'd2, 32'h20, 32'h11223344, 1'b1);
        idle(2);
        rlow = 0;
        wcount = 0;
        issue(1'b1, 3'd0, 32'h21, 32'h000000AA, 1'b1);
        idle(3);
        check("sb_ready_low_cycles", 32'(rlow), 32'd1);
        check("sb_write_cycles", 32'(wcount), 32'd1);
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
        idle(2);

        // Lane extraction, back-to-back.
        issue(1'b1, 3'd2, 32'h30, 32'h80FF7F01, 1'b1);
        issue(1'b0, 3'd0, 32'h31, 32'h0, 1'b1);
        issue(1'b0, 3'd0, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 3'd4, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 3'd1, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 3'd5, 32'h32, 32'h0, 1'b1);
        idle(2);

        // Error classification: no memory side effects.
        wcount = 0;
        issue(1'b0, 3'd2, 32'h02, 32'h0, 1'b1);
        issue(1'b1, 3'd1, 32'h401, 32'h1234, 1'b1);
        issue(1'b1, 3'd2, 32'h400, 32'h5678, 1'b1);
        issue(1'b0, 3'd3, 32'h00, 32'h0, 1'b1);
        issue(1'b1, 3'd3, 32'h04, 32'h9, 1'b1);
        issue(1'b1, 3'd4, 32'h08, 32'h9, 1'b1);
        idle(3);
        check("err_write_cycles", 32'(wcount), 32'd0);

        // Reset in the MERGE cycle abandons the store.
        issue(1'b1, 3'd1, 32'h40, 32'h0000BEEF, 1'b0);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("merge_rst_ready", 32'(req_ready), 32'd1);
        check("merge_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b1);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            we = 1'(($urandom % 2));
            if ($urandom % 16 == 0) f3 = 3'($urandom % 8);
            else begin
                f3 = f3_tab[$urandom % 5];
                if (we) f3 = {1'b0, f3[1:0]};
            end
            size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            addr = 32'($urandom_range(0, 1023));
            if ($urandom % 4 != 0) addr = addr & ~32'(size - 1);
            if ($urandom % 20 == 0) addr = 32'h400 + 32'($urandom_range(0, 65535));
            issue(we, f3, addr, $urandom, 1'b1);
            if ($urandom % 4 == 0) idle(1);
        end

        // Drain and final memory image.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 256; i++)
            check("mem_final", mem[i], {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
